// File: rtl/mem_access_ctrl.sv
// Purpose: MEM-stage load/store front end onto an addr_ok/data_ok SRAM bus (alignment check, lane steering, load extension).
// Latency: bus request one cycle after the access is seen; load result presented the cycle after data_ok.
// Backpressure: stall_mem holds MEM while a request or response is outstanding. Option macro: MEM_ACCESS_BADVADDR_EN adds badvaddr.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  ls_segsM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  input  logic        flushM,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic [3:0]  data_sram_wstrb,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic [31:0] rdataM,
  output logic        addr_error_lw,
  output logic        addr_error_sw,
  output logic        stall_mem
`ifdef MEM_ACCESS_BADVADDR_EN
  ,
  output logic [31:0] badvaddr
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DISCARD} state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } sram_cmd_t;

  state_t      state_q, state_d;
  sram_cmd_t   cmd_q, cmd_d;
  logic [3:0]  ld_kind_q;   // {lbu, lhu, lw, lh}; all zero for stores
  logic [31:0] rdata_q;
  logic [31:0] ld_ext;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic        op_lbu, op_sb, op_lhu, op_sh, op_lw, op_sw, op_lh;
  logic        misal_lw, misal_sw, issue, cap_rd, stall_raw;

  assign {op_lbu, op_sb, op_lhu, op_sh, op_lw, op_sw, op_lh} = ls_segsM;

  assign misal_lw = (op_lw && (addrM[1:0] != 2'b00)) || ((op_lh || op_lhu) && addrM[0]);
  assign misal_sw = (op_sw && (addrM[1:0] != 2'b00)) || (op_sh && addrM[0]);

  // Errors are only meaningful while no transaction is in flight; reset masks them.
  assign addr_error_lw = !rst && (state_q == IDLE) && misal_lw;
  assign addr_error_sw = !rst && (state_q == IDLE) && misal_sw;

  assign issue = (state_q == IDLE) && (ls_segsM != 7'd0) && !misal_lw && !misal_sw && !flushM;

  assign data_sram_req   = (state_q == REQ);
  assign data_sram_wr    = cmd_q.wr;
  assign data_sram_size  = cmd_q.size;
  assign data_sram_addr  = cmd_q.addr;
  assign data_sram_wdata = cmd_q.wdata;
  assign data_sram_wstrb = cmd_q.wstrb;
  assign rdataM          = (state_q == DONE) ? rdata_q : 32'h0;
  assign stall_mem       = stall_raw && !rst;

  // Build the bus command (size, lane strobes, replicated store data) from the MEM-stage op.
  always_comb begin
    cmd_d      = '0;
    cmd_d.wr   = op_sw | op_sh | op_sb;
    cmd_d.addr = addrM;
    if (op_lw || op_sw)                cmd_d.size = 2'd2;
    else if (op_lh || op_lhu || op_sh) cmd_d.size = 2'd1;
    else                               cmd_d.size = 2'd0;
    if (op_sw) begin
      cmd_d.wdata = wdataM;
      cmd_d.wstrb = 4'b1111;
    end else if (op_sh) begin
      cmd_d.wdata = {2{wdataM[15:0]}};
      cmd_d.wstrb = addrM[1] ? 4'b1100 : 4'b0011;
    end else if (op_sb) begin
      cmd_d.wdata = {4{wdataM[7:0]}};
      cmd_d.wstrb = 4'b0001 << addrM[1:0];
    end
  end

  // Select and extend the returned lane according to the issued load type.
  always_comb begin
    half_sel = cmd_q.addr[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
    case (cmd_q.addr[1:0])
      2'd0:    byte_sel = data_sram_rdata[7:0];
      2'd1:    byte_sel = data_sram_rdata[15:8];
      2'd2:    byte_sel = data_sram_rdata[23:16];
      default: byte_sel = data_sram_rdata[31:24];
    endcase
    ld_ext = 32'h0;
    if (ld_kind_q[1])      ld_ext = data_sram_rdata;
    else if (ld_kind_q[0]) ld_ext = {{16{half_sel[15]}}, half_sel};
    else if (ld_kind_q[2]) ld_ext = {16'h0, half_sel};
    else if (ld_kind_q[3]) ld_ext = {24'h0, byte_sel};
  end

  // Next-state, stall and load-capture decisions.
  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    cap_rd    = 1'b0;
    case (state_q)
      IDLE: begin
        stall_raw = issue;
        if (issue) state_d = REQ;
      end
      REQ: begin
        stall_raw = 1'b1;
        if (data_sram_addr_ok) begin
          if (data_sram_data_ok) begin
            state_d = DONE;
            cap_rd  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else if (flushM) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        stall_raw = 1'b1;
        // A flushed instruction owns no result: drop the response, even if it is arriving now.
        if (flushM) begin
          state_d = data_sram_data_ok ? IDLE : DISCARD;
        end else if (data_sram_data_ok) begin
          state_d = DONE;
          cap_rd  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      DISCARD: begin
        stall_raw = (ls_segsM != 7'd0);
        if (data_sram_data_ok) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Command and load-type registers, captured only when an access is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q     <= '0;
      ld_kind_q <= 4'h0;
    end else if (issue) begin
      cmd_q     <= cmd_d;
      ld_kind_q <= {op_lbu, op_lhu, op_lw, op_lh};
    end
  end

  // Load result register, written on the cycle the response is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rdata_q <= 32'h0;
    else if (cap_rd) rdata_q <= ld_ext;
  end

`ifdef MEM_ACCESS_BADVADDR_EN
  // Remember the faulting address whenever an alignment error is reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  badvaddr <= 32'h0;
    else if (addr_error_lw || addr_error_sw) badvaddr <= addrM;
  end
`else
  // No fault-address register in this build.
`endif

endmodule
